instr_fetch_unit: RTL

Front-end fetch stage that produces the instruction word whose opcode drives the control decoder. It generates word-aligned fetch addresses from a PC register and talks to instruction memory over a request/response handshake. Fetched {pc, instr} pairs are buffered in a small FIFO and presented to decode under valid/ready. Taken branches and jumps are applied through a redirect port, which flushes all stale work.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 86 ++++++++
 rtl/instr_fetch_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, the canonical NOP, major opcodes
// and the fetch FSM state encoding.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int unsigned OPCODE_W  = 7;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs; flush wins over
// push and pop in the same cycle.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [WIDTH-1:0]        data_i,
   output logic [WIDTH-1:0]        data_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en_s;
   logic             rd_en_s;

   // Pointer/count update; push/pop gated on space/data so a misuse cannot corrupt state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wr_en_s  = 1'b0;
      rd_en_s  = 1'b0;
      if (flush_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         wr_en_s = push_i && (count_q != CNT_W'(DEPTH));
         rd_en_s = pop_i && (count_q != {CNT_W{1'b0}});
         if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (wr_en_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, imem request/response FSM and a small buffer
// feeding decode. Redirects flush buffered and in-flight work.
module instr_fetch_unit #(
   parameter int unsigned     XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      opcode,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   import riscv_pkg::*;

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_t        state_q, state_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;

   logic                req_valid_s;
   logic                handshake_s;
   logic                push_s;
   logic                pop_s;
   logic                outstanding_s;
   logic [CNT_W-1:0]    count_s;
   logic [CNT_W:0]      in_flight_s;
   logic [CNT_W:0]      count_after_s;
   logic [2*XLEN-1:0]   head_s;
   logic                instr_valid_s;
   logic [XLEN-1:0]     instr_s;
   logic [XLEN-1:0]     instr_pc_s;

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect_valid),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .data_i  ({fetch_pc_q, imem_rsp_data}),
      .data_o  (head_s),
      .count_o (count_s)
   );

   // An accepted request awaiting its response reserves a buffer slot
   assign outstanding_s = (state_q == WAIT);
   assign in_flight_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, outstanding_s};
   assign count_after_s = {1'b0, count_s} + (CNT_W+1)'(1) - {{CNT_W{1'b0}}, pop_s};

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; redirect takes priority in every state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               state_d = IDLE;
            end else if (in_flight_s < (CNT_W+1)'(BUF_DEPTH)) begin
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (redirect_valid) begin
               state_d = handshake_s ? DRAIN : IDLE;
            end else if (handshake_s) begin
               state_d = WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (redirect_valid) begin
                  state_d = IDLE;
               end else if (count_after_s < (CNT_W+1)'(BUF_DEPTH)) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end else if (redirect_valid) begin
               state_d = DRAIN;
            end else begin
               state_d = WAIT;
            end
         end
         DRAIN: begin
            // The stale response retires the drain even if a new redirect lands with it
            if (imem_rsp_valid) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and PC next-value selection
   always_comb begin
      req_valid_s = rst_n && (state_q == REQ);
      handshake_s = req_valid_s && imem_req_ready;
      push_s      = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
      pop_s       = instr_valid_s && instr_ready && !redirect_valid;
      if (redirect_valid) begin
         pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      end else if (handshake_s) begin
         pc_d = pc_q + XLEN'(4);
      end else begin
         pc_d = pc_q;
      end
      if (handshake_s) begin
         fetch_pc_d = pc_q;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
   end

   // PC and in-flight address registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
      end else begin
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // Decode-side view of the buffer head, NOP/zero when empty
   always_comb begin
      instr_valid_s = rst_n && (count_s != {CNT_W{1'b0}});
      if (instr_valid_s) begin
         instr_s    = head_s[XLEN-1:0];
         instr_pc_s = head_s[2*XLEN-1:XLEN];
      end else begin
         instr_s    = XLEN'(NOP_INSTR);
         instr_pc_s = {XLEN{1'b0}};
      end
   end

   assign imem_req_valid = req_valid_s;
   assign imem_addr      = pc_q;
   assign instr_valid    = instr_valid_s;
   assign instr          = instr_s;
   assign instr_pc       = instr_pc_s;
   assign opcode         = instr_s[OPCODE_W-1:0];

endmodule
